// File: rtl/execute_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : execute_unit_pipe
// Purpose  : Registered execute stage between decode and memory.
//            - Operand select: op1 = sel1 ? data1 : data2.
//              op2 = sel_imm ? imm : (sel2 ? data2 : 1).
//            - Single-cycle ALU ops: PASS, ADD, SUB, AND, OR, NOT, SHL, SHR.
//            - Iterative shift-add multiplier, one step per cycle.
//            - Valid/ready handshake on both the input and the output side.
//            - Z/N/C/V flag register with selective update, and a
//              synchronous flush.
// Ports    : clk, rst (async, active-low), flush
//            in_valid/in_ready, sel1, sel2, sel_imm, alu_op, flag_en,
//            data1_val, data2_val, imm_val      -- upstream op
//            out_valid/out_ready, alu_out, flags -- downstream result
// Revision : 1.0  initial release
// ============================================================================
module execute_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel_imm,
  input  logic [3:0]       alu_op,
  input  logic             flag_en,
  input  logic [WIDTH-1:0] data1_val,
  input  logic [WIDTH-1:0] data2_val,
  input  logic [WIDTH-1:0] imm_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  localparam logic [3:0] C_OP_PASS = 4'd0;
  localparam logic [3:0] C_OP_ADD  = 4'd1;
  localparam logic [3:0] C_OP_SUB  = 4'd2;
  localparam logic [3:0] C_OP_AND  = 4'd3;
  localparam logic [3:0] C_OP_OR   = 4'd4;
  localparam logic [3:0] C_OP_NOT  = 4'd5;
  localparam logic [3:0] C_OP_SHL  = 4'd6;
  localparam logic [3:0] C_OP_SHR  = 4'd7;
  localparam logic [3:0] C_OP_MUL  = 4'd8;

  localparam logic [SHW-1:0] C_CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // State and datapath registers
  state_t             state_q,     state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q,   alu_out_d;
  logic [3:0]         flags_q,     flags_d;
  logic [SHW-1:0]     cnt_q,       cnt_d;
  logic [WIDTH-1:0]   mcand_q,     mcand_d;
  logic [WIDTH-1:0]   mplier_q,    mplier_d;
  logic [WIDTH-1:0]   acc_q,       acc_d;
  logic               flag_en_q,   flag_en_d;

  // Combinational signals
  logic [WIDTH-1:0]   w_op1;
  logic [WIDTH-1:0]   w_op2b;
  logic [WIDTH-1:0]   w_op2;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH:0]     w_shl_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flags;
  logic [WIDTH-1:0]   w_acc_step;
  logic [3:0]         w_mul_flags;
  logic               w_accept;
  logic               w_consume;

  assign in_ready  = rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  // Flush wins over an accept on the same edge.
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_consume = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign flags     = flags_q;

  // Operand select and single-cycle ALU with flag generation
  always_comb begin
    w_op1     = sel1 ? data1_val : data2_val;
    w_op2b    = sel2 ? data2_val : WIDTH'(1);
    w_op2     = sel_imm ? imm_val : w_op2b;
    w_sh      = w_op2[SHW-1:0];
    w_sum     = {1'b0, w_op1} + {1'b0, w_op2};
    w_diff    = w_op1 - w_op2;
    // One extra bit on top catches the last bit shifted out (0 for shift 0).
    w_shl_ext = {1'b0, w_op1} << w_sh;
    w_res     = w_op1;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (alu_op)
      C_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_op1[WIDTH-1] == w_op2[WIDTH-1]) &&
                (w_res[WIDTH-1] != w_op1[WIDTH-1]);
      end
      C_OP_SUB: begin
        w_res = w_diff;
        w_c   = (w_op1 < w_op2);
        w_v   = (w_op1[WIDTH-1] != w_op2[WIDTH-1]) &&
                (w_diff[WIDTH-1] != w_op1[WIDTH-1]);
      end
      C_OP_AND:  w_res = w_op1 & w_op2;
      C_OP_OR:   w_res = w_op1 | w_op2;
      C_OP_NOT:  w_res = ~w_op1;
      C_OP_SHL: begin
        w_res = w_shl_ext[WIDTH-1:0];
        w_c   = w_shl_ext[WIDTH];
      end
      C_OP_SHR:  w_res = w_op1 >> w_sh;
      C_OP_PASS: w_res = w_op1;
      default:   w_res = w_op1;
    endcase
    w_flags = {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
  end

  // One shift-add multiplier step
  always_comb begin
    w_acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    w_mul_flags = {1'b0, 1'b0, w_acc_step[WIDTH-1], (w_acc_step == '0)};
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    flag_en_d   = flag_en_q;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      if (alu_op == C_OP_MUL) begin
        state_d     = S_BUSY;
        mcand_d     = w_op1;
        mplier_d    = w_op2;
        acc_d       = '0;
        cnt_d       = '0;
        flag_en_d   = flag_en;
        // Either nothing was pending or the old result leaves this edge.
        out_valid_d = 1'b0;
      end else begin
        alu_out_d   = w_res;
        out_valid_d = 1'b1;
        if (flag_en) begin
          flags_d = w_flags;
        end
      end
    end else if (state_q == S_BUSY) begin
      acc_d    = w_acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == C_CNT_LAST) begin
        state_d     = S_IDLE;
        alu_out_d   = w_acc_step;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        if (flag_en_q) begin
          flags_d = w_mul_flags;
        end
      end
    end else if (w_consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= 4'b0000;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      flag_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      flag_en_q   <= flag_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_unit_pipe
// Purpose  : Directed vectors for execute_unit_pipe. Expected results and flags
//            are queued when an op is accepted. A monitor compares them on
//            every consumed output.
// Revision : 1.0  initial release
// ============================================================================
module tb_execute_unit_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         sel1;
  logic         sel2;
  logic         sel_imm;
  logic [3:0]   alu_op;
  logic         flag_en;
  logic [W-1:0] data1_val;
  logic [W-1:0] data2_val;
  logic [W-1:0] imm_val;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic [3:0]   flags;

  int total = 0;
  int bad   = 0;
  logic [19:0] sbq[$];

  always #5 clk = ~clk;

  execute_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel_imm   (sel_imm),
    .alu_op    (alu_op),
    .flag_en   (flag_en),
    .data1_val (data1_val),
    .data2_val (data2_val),
    .imm_val   (imm_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h with nothing expected", alu_out);
      end else begin
        e = sbq.pop_front();
        chk("result", {16'h0, alu_out}, {16'h0, e[19:4]});
        chk("flags", {28'h0, flags}, {28'h0, e[3:0]});
      end
    end
  end

  // Presents one op, waits for acceptance, queues the expectation if asked.
  task automatic issue(input logic [3:0] op, input logic s1, input logic s2, input logic si,
                       input logic fe, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] im, input logic push, input logic [15:0] eo,
                       input logic [3:0] ef, output int waits);
    alu_op = op; sel1 = s1; sel2 = s2; sel_imm = si; flag_en = fe;
    data1_val = d1; data2_val = d2; imm_val = im;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waits);
    end else if (push) begin
      sbq.push_back({eo, ef});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int cnt;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel1 = 1'b0; sel2 = 1'b0; sel_imm = 1'b0; alu_op = 4'd0; flag_en = 1'b0;
    data1_val = '0; data2_val = '0; imm_val = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_out", {16'h0, alu_out}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // ADD overflow, latency 1
    issue(4'd1, 1, 1, 0, 1, 16'h7FFF, 16'h0001, 16'h0, 1, 16'h8000, 4'b1010, w);
    chk("add_lat_valid", {31'h0, out_valid}, 32'h1);
    chk("add_lat_out", {16'h0, alu_out}, 32'h8000);
    // SUB to zero, then ADD without flag update
    issue(4'd2, 1, 1, 0, 1, 16'h0005, 16'h0005, 16'h0, 1, 16'h0000, 4'b0001, w);
    issue(4'd1, 1, 1, 0, 0, 16'h0001, 16'h0001, 16'h0, 1, 16'h0002, 4'b0001, w);
    // INC form (op2 = constant 1)
    issue(4'd1, 1, 0, 0, 1, 16'hFFFF, 16'h1234, 16'h0, 1, 16'h0000, 4'b0101, w);
    // Logic, shifts, pass, subtract corner cases
    issue(4'd3, 1, 1, 1, 1, 16'hF0F0, 16'h0000, 16'h0FF0, 1, 16'h00F0, 4'b0000, w);
    issue(4'd4, 0, 1, 1, 1, 16'hFFFF, 16'h1234, 16'h8001, 1, 16'h9235, 4'b0010, w);
    issue(4'd5, 1, 1, 0, 1, 16'h00FF, 16'h0000, 16'h0000, 1, 16'hFF00, 4'b0010, w);
    issue(4'd6, 1, 1, 1, 1, 16'hC001, 16'h0000, 16'h0002, 1, 16'h0004, 4'b0100, w);
    issue(4'd6, 1, 1, 1, 1, 16'h1001, 16'h0000, 16'h0013, 1, 16'h8008, 4'b0010, w);
    issue(4'd7, 1, 1, 1, 1, 16'h8000, 16'h0000, 16'h000F, 1, 16'h0001, 4'b0000, w);
    issue(4'd12, 1, 1, 0, 1, 16'h0000, 16'h5555, 16'h0000, 1, 16'h0000, 4'b0001, w);
    issue(4'd2, 1, 1, 0, 1, 16'h0003, 16'h0005, 16'h0000, 1, 16'hFFFE, 4'b0110, w);
    issue(4'd2, 1, 1, 0, 1, 16'h8000, 16'h0001, 16'h0000, 1, 16'h7FFF, 4'b1000, w);
    issue(4'd0, 1, 1, 0, 0, 16'hABCD, 16'h0000, 16'h0000, 1, 16'hABCD, 4'b1000, w);

    // MUL 300*300: busy for WIDTH cycles, result on the WIDTH-th edge
    issue(4'd8, 1, 1, 0, 1, 16'h012C, 16'h012C, 16'h0, 1, 16'h5F90, 4'b0000, w);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!in_ready && !out_valid) cnt++;
    end
    chk("mul_busy_cycles", cnt, 16);
    @(negedge clk);
    chk("mul_latency_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    // MUL whose low half wraps to zero
    issue(4'd8, 1, 1, 0, 1, 16'h0100, 16'h0100, 16'h0, 1, 16'h0000, 4'b0001, w);
    repeat (17) @(posedge clk);
    #1;

    // Backpressure: result held stable, no new accept
    out_ready = 1'b0;
    issue(4'd1, 1, 1, 0, 1, 16'h0003, 16'h0004, 16'h0, 1, 16'h0007, 4'b0000, w);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid && alu_out == 16'h0007 && !in_ready) cnt++;
    end
    chk("backpressure_hold", cnt, 5);
    @(posedge clk); #1 out_ready = 1'b1;
    // Back-to-back; the first also replaces the held result on the same edge
    issue(4'd1, 1, 1, 0, 1, 16'h0001, 16'h0001, 16'h0, 1, 16'h0002, 4'b0000, w);
    chk("b2b_wait_0", w, 0);
    issue(4'd1, 1, 1, 0, 1, 16'h0010, 16'h0020, 16'h0, 1, 16'h0030, 4'b0000, w);
    chk("b2b_wait_1", w, 0);
    issue(4'd1, 1, 1, 0, 1, 16'h7000, 16'h7000, 16'h0, 1, 16'hE000, 4'b1010, w);
    chk("b2b_wait_2", w, 0);

    // Flush on the 8th MUL cycle
    issue(4'd8, 1, 1, 0, 1, 16'h0003, 16'h0003, 16'h0, 0, 16'h0, 4'b0000, w);
    repeat (7) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
    chk("flush_flags", {28'h0, flags}, {28'h0, 4'b1010});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("flush_no_result", cnt, 0);

    // Asynchronous reset in the middle of a MUL
    @(posedge clk); #1;
    issue(4'd8, 1, 1, 0, 1, 16'h0003, 16'h0003, 16'h0, 0, 16'h0, 4'b0000, w);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_alu_out", {16'h0, alu_out}, 32'h0);
    chk("midrst_flags", {28'h0, flags}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    issue(4'd1, 1, 1, 0, 1, 16'hFFFF, 16'h0002, 16'h0, 1, 16'h0001, 4'b0100, w);

    cnt = 0;
    while (sbq.size() != 0 && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
